// File: rtl/dcache_axi_bridge.sv
// AXI3 master for the data cache: line refills, dirty-line writebacks and uncached
// single-beat accesses, with independent read and write state machines.
module dcache_axi_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  // AR channel
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [3:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic [1:0]                 arlock,
  output logic [3:0]                 arcache,
  output logic [2:0]                 arprot,
  output logic                       arvalid,
  input  logic                       arready,
  // R channel
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  // AW channel
  output logic [3:0]                 awid,
  output logic [31:0]                awaddr,
  output logic [3:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic [1:0]                 awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot,
  output logic                       awvalid,
  input  logic                       awready,
  // W channel
  output logic [3:0]                 wid,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  // B channel
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  // cache read side
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [31:0]                rd_req_addr,
  input  logic                       rd_req_uc,
  input  logic [1:0]                 rd_req_size,
  output logic                       rd_resp_valid,
  output logic [32*LINE_WORDS-1:0]   rd_resp_data,
  output logic                       rd_resp_err,
  // cache write side
  input  logic                       wr_req_valid,
  output logic                       wr_req_ready,
  input  logic [31:0]                wr_req_addr,
  input  logic                       wr_req_uc,
  input  logic [1:0]                 wr_req_size,
  input  logic [3:0]                 wr_req_strb,
  input  logic [32*LINE_WORDS-1:0]   wr_req_data,
  output logic                       wr_resp_valid,
  output logic                       wr_resp_err,
  output logic                       busy
);

  localparam int              BW        = $clog2(LINE_WORDS);
  localparam logic [31:0]     LINE_MASK = ~32'(LINE_WORDS * 4 - 1);
  localparam logic [3:0]      BURST_LEN = 4'(LINE_WORDS - 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

  r_state_t      r_state, r_state_nxt;
  w_state_t      w_state, w_state_nxt;

  logic [31:0]   r_addr;
  logic          r_uc;
  logic [1:0]    r_size;
  logic [BW-1:0] r_cnt;
  logic [31:0]   r_line [LINE_WORDS];

  logic [31:0]   w_addr;
  logic          w_uc;
  logic [1:0]    w_size;
  logic [3:0]    w_strb;
  logic [BW-1:0] w_cnt;
  logic [31:0]   w_line [LINE_WORDS];
  logic          aw_done, w_done;

  logic rd_accept, wr_accept, hazard, r_beat;
  logic aw_hs, w_hs, aw_fin, w_fin, b_hs;
  logic unused_ids;

  assign unused_ids = ^{rid, bid};

  // A read may not overtake a writeback of the same line still in flight.
  assign hazard       = (w_state != W_IDLE) && ((rd_req_addr & LINE_MASK) == (w_addr & LINE_MASK));
  assign rd_req_ready = (r_state == R_IDLE) && !hazard;
  assign wr_req_ready = (w_state == W_IDLE);
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign wr_accept    = wr_req_valid && wr_req_ready;
  assign r_beat       = (r_state == R_DATA) && rvalid;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || (w_hs && wlast);
  assign b_hs   = (w_state == W_RESP) && bvalid;

  assign busy = (r_state != R_IDLE) || (w_state != W_IDLE);

  // AXI request fields
  assign arid    = 4'(AXI_ID);
  assign araddr  = r_uc ? r_addr : (r_addr & LINE_MASK);
  assign arlen   = r_uc ? 4'd0 : BURST_LEN;
  assign arsize  = r_uc ? {1'b0, r_size} : 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  assign awid    = 4'(AXI_ID);
  assign awaddr  = w_uc ? w_addr : (w_addr & LINE_MASK);
  assign awlen   = w_uc ? 4'd0 : BURST_LEN;
  assign awsize  = w_uc ? {1'b0, w_size} : 3'd2;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign bready  = 1'b1;

  assign wid   = 4'(AXI_ID);
  assign wdata = w_uc ? w_line[0] : w_line[w_cnt];
  assign wstrb = w_uc ? w_strb : 4'hF;
  assign wlast = wvalid && (w_uc || (w_cnt == LAST_BEAT));

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) rd_resp_data[32*i +: 32] = r_line[i];
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // NOTE: next-state is defaulted to the current state before the case so no path leaves it unassigned (no latch).
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (rd_accept)        r_state_nxt = R_ADDR;
      R_ADDR:  if (arready)          r_state_nxt = R_DATA;
      R_DATA:  if (rvalid && rlast)  r_state_nxt = R_IDLE;
      default:                       r_state_nxt = R_IDLE;
    endcase
  end

  // NOTE: line buffers are reset on purpose: rd_resp_data must read zero straight out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid       <= 1'b0;
      r_addr        <= '0;
      r_uc          <= 1'b0;
      r_size        <= '0;
      r_cnt         <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_err   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) r_line[i] <= '0;
    end else begin
      rd_resp_valid <= r_beat && rlast;
      if (rd_accept) begin
        r_addr      <= rd_req_addr;
        r_uc        <= rd_req_uc;
        r_size      <= rd_req_size;
        r_cnt       <= '0;
        rd_resp_err <= 1'b0;
        arvalid     <= 1'b1;
        for (int i = 0; i < LINE_WORDS; i++) r_line[i] <= '0;
      end else begin
        if (arvalid && arready) arvalid <= 1'b0;
        if (r_beat) begin
          r_line[r_cnt] <= rdata;
          r_cnt         <= r_cnt + 1'b1;
          if (rresp != 2'b00) rd_resp_err <= 1'b1;
        end
      end
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_accept)        w_state_nxt = W_XFER;
      W_XFER:  if (aw_fin && w_fin)  w_state_nxt = W_RESP;
      W_RESP:  if (bvalid)           w_state_nxt = W_IDLE;
      default:                       w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      w_addr        <= '0;
      w_uc          <= 1'b0;
      w_size        <= '0;
      w_strb        <= '0;
      w_cnt         <= '0;
      wr_resp_valid <= 1'b0;
      wr_resp_err   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) w_line[i] <= '0;
    end else begin
      wr_resp_valid <= b_hs;
      if (b_hs) wr_resp_err <= (bresp != 2'b00);
      if (wr_accept) begin
        w_addr  <= wr_req_addr;
        w_uc    <= wr_req_uc;
        w_size  <= wr_req_size;
        w_strb  <= wr_req_strb;
        w_cnt   <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        for (int i = 0; i < LINE_WORDS; i++) w_line[i] <= wr_req_data[32*i +: 32];
      end else begin
        if (aw_hs) begin
          awvalid <= 1'b0;
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          if (wlast) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Randomized bench for dcache_axi_bridge: a behavioural AXI slave plus a line-level
// model of what each refill, writeback and uncached access must look like.
module tb_dcache_axi_bridge;
  localparam int LW = 8;
  localparam logic [31:0] LMASK = ~32'(LW * 4 - 1);

  logic aclk = 1'b0;
  logic aresetn;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid, wr_req_strb;
  logic [31:0] araddr, awaddr, wdata, rdata, rd_req_addr, wr_req_addr;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp, rd_req_size, wr_req_size;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready, rd_req_valid, rd_req_ready, rd_req_uc, rd_resp_valid, rd_resp_err;
  logic wr_req_valid, wr_req_ready, wr_req_uc, wr_resp_valid, wr_resp_err, busy;
  logic [32*LW-1:0] rd_resp_data, wr_req_data;

  dcache_axi_bridge #(.LINE_WORDS(LW), .AXI_ID(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_uc(rd_req_uc), .rd_req_size(rd_req_size), .rd_resp_valid(rd_resp_valid),
    .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_uc(wr_req_uc), .wr_req_size(wr_req_size), .wr_req_strb(wr_req_strb),
    .wr_req_data(wr_req_data), .wr_resp_valid(wr_resp_valid), .wr_resp_err(wr_resp_err),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing store seen by the slave; the expected line is derived from the request address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0193) ^ 32'hC3A5_1E0F;
  endfunction

  typedef struct { logic [31:0] addr; logic [3:0] len; logic [2:0] size; } ax_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;

  // slave knobs
  int ar_pct = 100, r_pct = 100, aw_pct = 100, w_pct = 100;
  int aw_delay = 0, b_delay = 0, err_beat = -1;
  bit w_alt = 0, data_mode = 0;
  logic [1:0] b_resp_k = 2'b00;

  ax_t    ar_q[$], ar_log[$], aw_log[$];
  wbeat_t w_log[$];
  ax_t    r_cur;
  int     r_left = 0, r_idx = 0, cur_beat = -1;
  int     b_pending = 0, b_wait = 0, aw_stall = 0;
  bit     aw_flag = 0, wl_flag = 0, w_tog = 0;
  bit     prev_ar_wait = 0, prev_aw_wait = 0, prev_w_wait = 0;
  int unsigned b_cyc, aw_hs_cyc, wl_hs_cyc;

  // AXI slave: decisions are made at the falling edge and take effect at the next rising edge.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        ar_q.delete(); r_left = 0; cur_beat = -1; b_pending = 0; aw_flag = 0; wl_flag = 0;
        aw_stall = 0; prev_ar_wait = 0; prev_aw_wait = 0; prev_w_wait = 0;
      end else begin
        if (prev_ar_wait) check("arvalid_held", arvalid, 1);
        if (prev_aw_wait) check("awvalid_held", awvalid, 1);
        if (prev_w_wait)  check("wvalid_held", wvalid, 1);
        bvalid = 0;
        if (b_pending > 0) begin
          if (b_wait > 0) b_wait--;
          else begin bvalid = 1; bresp = b_resp_k; b_pending--; b_cyc = cyc; end
        end
        rvalid = 0; rlast = 0; rresp = 0;
        if (r_left == 0 && ar_q.size() > 0) begin
          r_cur = ar_q.pop_front(); r_left = int'(r_cur.len) + 1; r_idx = 0;
        end
        if (r_left > 0 && $urandom_range(99) < r_pct) begin
          rvalid = 1;
          if (data_mode)            rdata = 32'h11 * (r_idx + 1);
          else if (r_cur.len == 0)  rdata = mem_word(r_cur.addr & ~32'h3);
          else                      rdata = mem_word(r_cur.addr + 32'(4 * r_idx));
          rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
          rlast = (r_left == 1);
          cur_beat = r_idx; r_idx++; r_left--;
        end
        arready = ($urandom_range(99) < ar_pct);
        if (arvalid && arready) begin
          ar_q.push_back('{araddr, arlen, arsize});
          ar_log.push_back('{araddr, arlen, arsize});
        end
        prev_ar_wait = arvalid && !arready;
        if (awvalid && aw_stall < aw_delay) begin awready = 0; aw_stall++; end
        else awready = ($urandom_range(99) < aw_pct);
        if (awvalid && awready) begin
          aw_log.push_back('{awaddr, awlen, awsize}); aw_flag = 1; aw_stall = 0; aw_hs_cyc = cyc;
        end
        prev_aw_wait = awvalid && !awready;
        w_tog = !w_tog;
        wready = w_alt ? w_tog : ($urandom_range(99) < w_pct);
        if (wvalid && wready) begin
          w_log.push_back('{wdata, wstrb, wlast});
          if (wlast) begin wl_flag = 1; wl_hs_cyc = cyc; end
        end
        prev_w_wait = wvalid && !wready;
        if (aw_flag && wl_flag) begin b_pending++; b_wait = b_delay; aw_flag = 0; wl_flag = 0; end
      end
    end
  end

  // response monitor
  int rd_pulses = 0, wr_pulses = 0;
  int unsigned rd_pulse_cyc, wr_pulse_cyc;
  logic [32*LW-1:0] rd_data_cap;
  logic rd_err_cap, wr_err_cap;
  initial begin
    forever begin
      @(negedge aclk);
      if (rd_resp_valid) begin
        rd_pulses++; rd_pulse_cyc = cyc; rd_data_cap = rd_resp_data; rd_err_cap = rd_resp_err;
      end
      if (wr_resp_valid) begin
        wr_pulses++; wr_pulse_cyc = cyc; wr_err_cap = wr_resp_err;
      end
    end
  end

  int rd_pulse_base, wr_pulse_base;
  int unsigned rd_acc_cyc, wr_acc_cyc;
  logic rd_first_ready;

  task automatic rd_issue(input logic [31:0] a, input logic uc, input logic [1:0] sz);
    bit ok = 0;
    @(negedge aclk);
    rd_req_valid = 1; rd_req_addr = a; rd_req_uc = uc; rd_req_size = sz;
    rd_pulse_base = rd_pulses;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (i == 0) rd_first_ready = rd_req_ready;
      if (rd_req_ready) begin ok = 1; break; end
      @(negedge aclk);
    end
    rd_acc_cyc = cyc;
    if (!ok) check("rd_accept_timeout", 0, 1);
    @(negedge aclk);
    rd_req_valid = 0;
  endtask

  task automatic rd_wait(input logic [31:0] a, input logic uc, input logic [1:0] sz, input int exp_lat);
    int t = 0;
    ax_t e;
    logic [31:0] base, expw;
    while (rd_pulses == rd_pulse_base && t < 2000) begin @(negedge aclk); #2; t++; end
    if (rd_pulses == rd_pulse_base) begin check("rd_resp_timeout", 0, 1); return; end
    if (ar_log.size() == 0) begin check("ar_handshake_seen", 0, 1); return; end
    e = ar_log.pop_front();
    base = uc ? a : (a & LMASK);
    check("araddr", e.addr, base);
    check("arlen", e.len, uc ? 0 : LW - 1);
    check("arsize", e.size, uc ? {1'b0, sz} : 3'd2);
    for (int i = 0; i < LW; i++) begin
      if (uc)             expw = (i == 0) ? mem_word(a & ~32'h3) : 32'h0;
      else if (data_mode) expw = 32'h11 * (i + 1);
      else                expw = mem_word(base + 32'(4 * i));
      check($sformatf("rd_word%0d", i), rd_data_cap[32*i +: 32], expw);
    end
    check("rd_err", rd_err_cap, uc ? (err_beat == 0) : (err_beat >= 0 && err_beat < LW));
    if (exp_lat >= 0) check("rd_latency", rd_pulse_cyc - rd_acc_cyc, exp_lat);
    @(negedge aclk); #1;
    check("rd_pulse_one_cycle", rd_resp_valid, 0);
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic uc, input logic [1:0] sz,
                          input logic [3:0] strb, input logic [32*LW-1:0] line);
    bit ok = 0;
    @(negedge aclk);
    wr_req_valid = 1; wr_req_addr = a; wr_req_uc = uc; wr_req_size = sz;
    wr_req_strb = strb; wr_req_data = line;
    wr_pulse_base = wr_pulses;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (wr_req_ready) begin ok = 1; break; end
      @(negedge aclk);
    end
    wr_acc_cyc = cyc;
    if (!ok) check("wr_accept_timeout", 0, 1);
    @(negedge aclk);
    wr_req_valid = 0;
  endtask

  task automatic wr_wait(input logic [31:0] a, input logic uc, input logic [1:0] sz,
                         input logic [3:0] strb, input logic [32*LW-1:0] line);
    int t = 0;
    int nb;
    ax_t e;
    while (wr_pulses == wr_pulse_base && t < 2000) begin @(negedge aclk); #2; t++; end
    if (wr_pulses == wr_pulse_base) begin check("wr_resp_timeout", 0, 1); return; end
    if (aw_log.size() == 0) begin check("aw_handshake_seen", 0, 1); return; end
    e = aw_log.pop_front();
    check("awaddr", e.addr, uc ? a : (a & LMASK));
    check("awlen", e.len, uc ? 0 : LW - 1);
    check("awsize", e.size, uc ? {1'b0, sz} : 3'd2);
    nb = uc ? 1 : LW;
    check("w_beat_count", w_log.size(), nb);
    for (int i = 0; i < nb && i < w_log.size(); i++) begin
      check($sformatf("wdata%0d", i), w_log[i].data, line[32*i +: 32]);
      check($sformatf("wstrb%0d", i), w_log[i].strb, uc ? strb : 4'hF);
      check($sformatf("wlast%0d", i), w_log[i].last, i == nb - 1);
    end
    w_log.delete();
    check("wr_err", wr_err_cap, b_resp_k != 2'b00);
    check("wr_resp_after_b", wr_pulse_cyc, b_cyc + 1);
  endtask

  function automatic logic [32*LW-1:0] rand_line();
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  logic [32*LW-1:0] line;
  logic [31:0] ra;
  logic rc;
  logic [1:0] rs;
  logic [3:0] rst4;
  int base_cnt;

  initial begin
    aresetn = 0;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_uc = 0; rd_req_size = 0;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_uc = 0; wr_req_size = 0; wr_req_strb = 0; wr_req_data = 0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_rd_resp_valid", rd_resp_valid, 0);
    check("rst_wr_resp_valid", wr_resp_valid, 0);
    check("rst_rd_err", rd_resp_err, 0);
    check("rst_wr_err", wr_resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_ready", rd_req_ready, 1);
    check("rst_wr_ready", wr_req_ready, 1);
    check("rst_rd_data_w0", rd_resp_data[31:0], 0);
    check("arburst_incr", arburst, 1);
    check("rready_const", rready, 1);
    check("bready_const", bready, 1);
    @(negedge aclk);
    aresetn = 1;
    repeat (2) @(negedge aclk);

    // cached refill with best-case timing and recognisable beat data
    data_mode = 1;
    rd_issue(32'h8000_1234, 0, 2'd2);
    rd_wait(32'h8000_1234, 0, 2'd2, LW + 2);
    check("refill_word0", rd_resp_data[31:0], 32'h11);
    repeat (3) @(negedge aclk);
    check("refill_word7_stable", rd_resp_data[32*7 +: 32], 32'h88);
    data_mode = 0;

    // uncached byte store
    line = '0; line[31:0] = 32'hAB00_0000;
    wr_issue(32'h1FAF_F003, 1, 2'd0, 4'b1000, line);
    wr_wait(32'h1FAF_F003, 1, 2'd0, 4'b1000, line);

    // uncached halfword load
    rd_issue(32'h2000_0006, 1, 2'd1);
    rd_wait(32'h2000_0006, 1, 2'd1, -1);

    // writeback to line 0x100 overlapping a refill of line 0x200
    b_delay = 8;
    line = rand_line();
    wr_issue(32'h0000_0100, 0, 2'd2, 4'hF, line);
    rd_issue(32'h0000_0200, 0, 2'd2);
    check("conc_rd_ready", rd_first_ready, 1);
    check("conc_overlap", wr_pulses == wr_pulse_base, 1);
    wr_wait(32'h0000_0100, 0, 2'd2, 4'hF, line);
    rd_wait(32'h0000_0200, 0, 2'd2, -1);

    // read to a line whose writeback is still in flight
    b_delay = 15;
    line = rand_line();
    wr_issue(32'h0000_0300, 0, 2'd2, 4'hF, line);
    rd_issue(32'h0000_0304, 0, 2'd2);
    check("haz_ready_low", rd_first_ready, 0);
    check("haz_accept_after_wr_resp", (wr_pulses > wr_pulse_base) && (rd_acc_cyc >= wr_pulse_cyc), 1);
    wr_wait(32'h0000_0300, 0, 2'd2, 4'hF, line);
    rd_wait(32'h0000_0304, 0, 2'd2, -1);
    b_delay = 0;

    // writeback under AW stall and alternating W backpressure
    aw_delay = 5; w_alt = 1;
    line = rand_line();
    wr_issue(32'h0040_0080, 0, 2'd2, 4'hF, line);
    wr_wait(32'h0040_0080, 0, 2'd2, 4'hF, line);
    check("bp_resp_after_aw", wr_pulse_cyc > aw_hs_cyc + 1, 1);
    check("bp_resp_after_wlast", wr_pulse_cyc > wl_hs_cyc + 1, 1);
    aw_delay = 0; w_alt = 0;

    // read error on beat 3, then a clean refill
    err_beat = 3;
    rd_issue(32'h0001_0040, 0, 2'd2);
    rd_wait(32'h0001_0040, 0, 2'd2, -1);
    err_beat = -1;
    rd_issue(32'h0001_0060, 0, 2'd2);
    rd_wait(32'h0001_0060, 0, 2'd2, -1);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      ar_pct = $urandom_range(100, 30); r_pct = $urandom_range(100, 30);
      aw_pct = $urandom_range(100, 30); w_pct = $urandom_range(100, 30);
      b_delay = $urandom_range(3);
      err_beat = ($urandom_range(3) == 0) ? int'($urandom_range(LW - 1)) : -1;
      b_resp_k = ($urandom_range(4) == 0) ? 2'b10 : 2'b00;
      ra = $urandom; rc = $urandom_range(1); rs = 2'($urandom_range(2)); rst4 = 4'($urandom);
      if ($urandom_range(1) == 0) begin
        rd_issue(ra, rc, rs);
        rd_wait(ra, rc, rs, -1);
      end else begin
        line = rand_line();
        wr_issue(ra, rc, rs, rst4, line);
        wr_wait(ra, rc, rs, rst4, line);
      end
    end
    ar_pct = 100; r_pct = 100; aw_pct = 100; w_pct = 100; b_delay = 0; err_beat = -1; b_resp_k = 0;

    // reset during beat 4 of a refill
    rd_issue(32'h0000_4000, 0, 2'd2);
    base_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk); #1;
      if (rvalid && cur_beat == 4) begin base_cnt = 1; break; end
    end
    check("rst_beat4_seen", base_cnt, 1);
    #2 aresetn = 0;
    #1;
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rd_resp_valid", rd_resp_valid, 0);
    check("midrst_rd_ready", rd_req_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rd_data_w0", rd_resp_data[31:0], 0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    ar_log.delete();
    repeat (20) @(negedge aclk);
    #2;
    check("midrst_no_pulse", rd_pulses, rd_pulse_base);
    check("midrst_ready_after", rd_req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
